// File: rtl/reg_file2_pkg.sv
// reg_file2_pkg: shared sizing constants and register-index type for reg_file2
package reg_file2_pkg;
    localparam int REG_WIDTH = 16;
    localparam int REG_COUNT = 16;
    localparam int REG_SEL_WIDTH = 4;
    typedef logic [REG_SEL_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file2_register16.sv
// register16: 16-bit register with synchronous reset and load enable
module register16
    import reg_file2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] d,
    output logic [REG_WIDTH-1:0] q
);
    always_ff @(posedge clk)
        q <= rst ? '0 : load ? d : q;
endmodule

// File: rtl/reg_file2.sv
// reg_file2: 16x16 register file, one synchronous write port, two combinational read ports
module reg_file2
    import reg_file2_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 WriteEnable,
    input  reg_idx_t             SelectInput,
    input  reg_idx_t             SelectA,
    input  reg_idx_t             SelectB,
    input  logic [REG_WIDTH-1:0] In,
    output logic [REG_WIDTH-1:0] A,
    output logic [REG_WIDTH-1:0] B
);
    logic [REG_COUNT-1:0] load;
    logic [REG_WIDTH-1:0] regs [REG_COUNT];
    always_comb
        load = WriteEnable ? REG_COUNT'(1) << SelectInput : '0;
    for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
        register16 u_reg (
            .clk (Clock),
            .rst (Reset),
            .load(load[i]),
            .d   (In),
            .q   (regs[i])
        );
    end
    always_comb begin
        A = regs[SelectA];
        B = regs[SelectB];
    end
endmodule

// File: tb/tb_reg_file2.sv
// tb_reg_file2: randomized and directed self-checking bench for reg_file2
module tb_reg_file2;
    logic        clk = 0;
    logic        rst, we;
    logic [3:0]  sel_in, sel_a, sel_b;
    logic [15:0] din, a, b;
    logic [15:0] mdl [16];
    logic        mvalid = 0;
    int          tests = 0;
    int          fails = 0;

    reg_file2 dut (
        .Clock      (clk),
        .Reset      (rst),
        .WriteEnable(we),
        .SelectInput(sel_in),
        .SelectA    (sel_a),
        .SelectB    (sel_b),
        .In         (din),
        .A          (a),
        .B          (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Reference: an array of register values updated by the reset/write rules
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mdl[k] <= '0;
            mvalid <= 1'b1;
        end else if (we && mvalid) begin
            mdl[sel_in] <= din;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_a", a, mdl[sel_a]);
            chk("model_b", b, mdl[sel_b]);
        end
    end

    initial begin
        rst = 1; we = 0; sel_in = 0; sel_a = 0; sel_b = 0; din = 0;
        step;
        step;
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            sel_a = 4'(i); sel_b = 4'(15 - i);
            #1;
            chk("reset_a", a, 16'h0000);
            chk("reset_b", b, 16'h0000);
            step;
        end
        we = 1; sel_in = 5; din = 16'd37;
        step;
        we = 0; sel_a = 5;
        #1 chk("write_r5", a, 16'd37);
        sel_a = 12;
        #1 chk("untouched_r12", a, 16'd0);
        sel_in = 5; din = 16'd42;
        repeat (3) step;
        sel_a = 5;
        #1 chk("we_low_hold", a, 16'd37);
        for (int i = 0; i < 16; i++) begin
            we = 1; sel_in = 4'(i); din = 16'hA000 + 16'(i);
            step;
        end
        we = 0;
        for (int i = 0; i < 16; i++) begin
            sel_a = 4'(i); sel_b = 4'(15 - i);
            #1;
            chk("sweep_a", a, 16'hA000 + 16'(i));
            chk("sweep_b", b, 16'hA00F - 16'(i));
            step;
        end
        sel_a = 7; sel_b = 7;
        #1;
        chk("same_sel_a", a, 16'hA007);
        chk("same_sel_b", b, 16'hA007);
        step;
        we = 1; sel_in = 4; din = 16'd111;
        step;
        din = 16'd222;
        step;
        we = 0; sel_a = 4;
        #1 chk("last_write_wins", a, 16'd222);
        step;
        we = 1; sel_in = 3; din = 16'h0000;
        step;
        sel_a = 3; sel_b = 3; din = 16'h1234;
        #1;
        chk("no_bypass_a", a, 16'h0000);
        chk("no_bypass_b", b, 16'h0000);
        step;
        we = 0;
        #1;
        chk("after_edge_a", a, 16'h1234);
        chk("after_edge_b", b, 16'h1234);
        step;
        repeat (400) begin
            rst = ($urandom % 25) == 0;
            we = 1'($urandom);
            sel_in = 4'($urandom); sel_a = 4'($urandom); sel_b = 4'($urandom);
            din = 16'($urandom);
            step;
        end
        rst = 0; we = 1;
        for (int i = 0; i < 16; i++) begin
            sel_in = 4'(i); din = 16'($urandom) | 16'h0001;
            step;
        end
        rst = 1; we = 1; sel_in = 9; din = 16'hFFFF;
        step;
        rst = 0; we = 0;
        for (int i = 0; i < 16; i++) begin
            sel_a = 4'(i); sel_b = 9;
            #1;
            chk("reset_prio_a", a, 16'h0000);
            chk("reset_prio_r9", b, 16'h0000);
            step;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
